// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: frame state encodings and default bit timing, so the
// readout stage, this transmitter and the bench all agree on one bit time.
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   // 50 MHz system clock divided down to 115200 baud
   localparam int UART_CLKS_PER_BIT = 434;
   localparam int UART_FIFO_DEPTH   = 4;
   localparam int UART_PTR_W        = 2;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte push port and line/status outputs of the UART transmitter.
// The readout stage (or a bench) is the master; the transmitter is the slave.
interface uart_tx_fifo_if;
   import uart_tx_fifo_pkg::*;

   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       busy;
   logic       overflow;
   logic       tx;

   modport master (
      output wr_en, wr_data,
      input  full, empty, busy, overflow, tx
   );

   modport slave (
      input  wr_en, wr_data,
      output full, empty, busy, overflow, tx
   );

endinterface

// File: rtl/uart_tx_fifo_byte_fifo.sv
// Count-based byte FIFO built from a register array. full/empty are decoded from
// the registered count; overflow is sticky until reset.
module uart_byte_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int FIFO_DEPTH = UART_FIFO_DEPTH,
   parameter int PTR_W      = UART_PTR_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       rd_en,
   output logic [7:0] rd_data,
   output logic       full,
   output logic       empty,
   output logic       overflow
);

   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [7:0]       mem_q [FIFO_DEPTH];
   logic [7:0]       mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             push;
   logic             pop;

   assign full     = (count_q == DEPTH_CNT);
   assign empty    = (count_q == '0);
   assign overflow = overflow_q;
   assign rd_data  = mem_q[rd_ptr_q];

   // A write while full is dropped even if a pop frees a slot on the same edge
   assign push = wr_en && !full;
   assign pop  = rd_en && !empty;

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (wr_en & full);
      if (push) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; serial back end of the RAM readout.
// tx is registered and trails the frame state by one cycle.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = UART_FIFO_DEPTH,
   parameter int PTR_W        = UART_PTR_W
) (
   input logic           clk,
   input logic           reset,
   uart_tx_fifo_if.slave bus
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [7:0]        shift_q, shift_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic              tx_q, tx_d;
   logic              baud_last;
   logic              pop;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_overflow;
   logic [7:0]        fifo_data;

   uart_byte_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .PTR_W      (PTR_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (bus.wr_en),
      .wr_data  (bus.wr_data),
      .rd_en    (pop),
      .rd_data  (fifo_data),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .overflow (fifo_overflow)
   );

   assign baud_last    = (baud_q == BAUD_LAST);
   assign bus.full     = fifo_full;
   assign bus.empty    = fifo_empty;
   assign bus.overflow = fifo_overflow;
   assign bus.busy     = (state_q != IDLE);
   assign bus.tx       = tx_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty) state_d = START;
         START:   if (baud_last) state_d = DATA;
         DATA:    if (baud_last && (bit_idx_q == 3'd7)) state_d = STOP;
         STOP:    if (baud_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Baud counter restarts on every state entry; shift reg loads on the IDLE pop
   always_comb begin
      pop       = (state_q == IDLE) && !fifo_empty;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      baud_d    = baud_q;
      tx_d      = 1'b1;

      if ((state_d != state_q) || (state_q == IDLE) || baud_last) begin
         baud_d = '0;
      end else begin
         baud_d = baud_q + 1'b1;
      end

      if (pop) begin
         shift_d   = fifo_data;
         bit_idx_d = 3'd0;
      end else if ((state_q == DATA) && baud_last) begin
         shift_d   = {1'b0, shift_q[7:1]};
         bit_idx_d = bit_idx_q + 3'd1;
      end

      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase
   end

endmodule
